bitrev_swap_gen: RTL and testbench

Sequential, parametrised bit-reversal address generator for in-place NTT reordering in the PQ extension. On a start command it walks every index `i` of a 2^n-entry polynomial and computes `j = bitrev_n(i)` for a runtime-selected `n` (1..MaxBits). It emits each swap pair (i, j) as base-offset word or byte addresses over a valid/ready stream. It sits between the PQ instruction decoder and the WDR/DMEM load-store sequencer.

---
 rtl/otbn_pq_pkg.sv | 17 +
 rtl/bitrev_var.sv | 27 ++
 rtl/bitrev_swap_gen.sv | 160 ++++++++++++++++
 tb/tb_bitrev_swap_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/otbn_pq_pkg.sv
// Shared types and constants for the PQ extension datapath blocks.
package otbn_pq_pkg;

   typedef enum logic {
      BitrevOpPq      = 1'b0,
      BitrevOpPqShift = 1'b1
   } bitrev_pq_op_e;

   localparam int BitrevMaxBits = 12;

   typedef enum logic [1:0] {
      Idle = 2'd0,
      Run  = 2'd1,
      Done = 2'd2
   } bitrev_swap_state_e;

endpackage

// File: rtl/bitrev_var.sv
// Combinational bit reverse of the low n bits of value; bits at and above n
// in the result are zero.
module bitrev_var
   import otbn_pq_pkg::*;
#(
   parameter  int MaxBits = BitrevMaxBits,
   localparam int NbW     = $clog2(MaxBits + 1)
) (
   input  logic [MaxBits-1:0] value_i,
   input  logic [NbW-1:0]     n_i,
   output logic [MaxBits-1:0] rev_o
);

   logic [MaxBits-1:0] full_rev;
   logic [NbW-1:0]     shamt;

   // Reverse the whole word, then shift the wanted n bits down to the bottom.
   always_comb begin
      full_rev = '0;
      for (int k = 0; k < MaxBits; k++) begin
         full_rev[k] = value_i[MaxBits-1-k];
      end
      shamt = NbW'(MaxBits) - n_i;
      rev_o = full_rev >> shamt;
   end

endmodule

// File: rtl/bitrev_swap_gen.sv
// Bit-reversal swap-pair address generator for in-place NTT reordering.
// Define OTBN_PQ_BITREV_SKIP_EN to emit only the i < j swap pairs.
module bitrev_swap_gen
   import otbn_pq_pkg::*;
#(
   parameter  int MaxBits = BitrevMaxBits,
   parameter  int AddrW   = 32,
   localparam int NbW     = $clog2(MaxBits + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic [NbW-1:0] nof_bits_i,
   input  bitrev_pq_op_e op_i,
   input  logic [AddrW-1:0] base_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          err_o,
   output logic          pair_valid_o,
   input  logic          pair_ready_i,
   output logic [AddrW-1:0] addr_a_o,
   output logic [AddrW-1:0] addr_b_o
);

   localparam int CntW = MaxBits + 1;

   function automatic logic [AddrW-1:0] idx_addr(input logic [AddrW-1:0] base,
                                                 input logic [CntW-1:0]  idx,
                                                 input bitrev_pq_op_e    op);
      logic [AddrW-1:0] off;
      off = AddrW'(idx);
      if (op == BitrevOpPqShift) begin
         off = off << 2;
      end
      return base + off;
   endfunction

   bitrev_swap_state_e state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [NbW-1:0]     n_p0, n_d;
   bitrev_pq_op_e      op_p0, op_d;
   logic [AddrW-1:0]   base_p0, base_d;
   logic               vld_p1, vld_d;
   logic [AddrW-1:0]   addr_a_p1, addr_a_d;
   logic [AddrW-1:0]   addr_b_p1, addr_b_d;
   logic               err_q, err_d;
   logic               done_q, done_d;

   logic [MaxBits-1:0] rev;
   logic [CntW-1:0]    end_cnt;
   logic               slot_free;
   logic               qualify;

   bitrev_var #(
      .MaxBits (MaxBits)
   ) u_bitrev_var (
      .value_i (cnt_q[MaxBits-1:0]),
      .n_i     (n_p0),
      .rev_o   (rev)
   );

   assign end_cnt   = CntW'(1) << n_p0;
   assign slot_free = !vld_p1 || pair_ready_i;

`ifdef OTBN_PQ_BITREV_SKIP_EN
   assign qualify = cnt_q < {1'b0, rev};
`else
   assign qualify = 1'b1;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      n_d      = n_p0;
      op_d     = op_p0;
      base_d   = base_p0;
      vld_d    = vld_p1;
      addr_a_d = addr_a_p1;
      addr_b_d = addr_b_p1;
      err_d    = 1'b0;
      done_d   = 1'b0;

      unique case (state_q)
         Idle: begin
            if (start_i) begin
               if ((nof_bits_i != '0) && (nof_bits_i <= NbW'(MaxBits))) begin
                  n_d     = nof_bits_i;
                  op_d    = op_i;
                  base_d  = base_i;
                  cnt_d   = '0;
                  state_d = Run;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         Run: begin
            // Nothing moves while a presented pair is stalled by the consumer.
            if (slot_free) begin
               if (cnt_q == end_cnt) begin
                  vld_d   = 1'b0;
                  state_d = Done;
               end else begin
                  vld_d = qualify;
                  if (qualify) begin
                     addr_a_d = idx_addr(base_p0, cnt_q, op_p0);
                     addr_b_d = idx_addr(base_p0, {1'b0, rev}, op_p0);
                  end
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end

         Done: begin
            done_d  = 1'b1;
            state_d = Idle;
         end

         default: begin
            state_d = Idle;
         end
      endcase
   end

   // Stage boundary: command latch, counter and output pair register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= Idle;
         cnt_q     <= '0;
         vld_p1    <= 1'b0;
         addr_a_p1 <= '0;
         addr_b_p1 <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         vld_p1    <= vld_d;
         addr_a_p1 <= addr_a_d;
         addr_b_p1 <= addr_b_d;
         err_q     <= err_d;
         done_q    <= done_d;
      end
   end

   always_ff @(posedge clk_i) begin
      n_p0    <= n_d;
      op_p0   <= op_d;
      base_p0 <= base_d;
   end

   assign busy_o       = (state_q != Idle);
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign pair_valid_o = vld_p1;
   assign addr_a_o     = addr_a_p1;
   assign addr_b_o     = addr_b_p1;

endmodule

// File: tb/tb_bitrev_swap_gen.sv
// Scoreboard bench for bitrev_swap_gen against a behavioural permutation model.
module tb_bitrev_swap_gen;
   import otbn_pq_pkg::*;

   localparam int MaxBits = 12;
   localparam int AddrW   = 32;
   localparam int NbW     = $clog2(MaxBits + 1);

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
   } pair_t;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             start_i;
   logic [NbW-1:0]   nof_bits_i;
   bitrev_pq_op_e    op_i;
   logic [AddrW-1:0] base_i;
   logic             busy_o, done_o, err_o, pair_valid_o;
   logic             pair_ready_i;
   logic [AddrW-1:0] addr_a_o, addr_b_o;

   pair_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    stalls = 0;
   int    rdy_mode = 0;

   bitrev_swap_gen #(.MaxBits(MaxBits), .AddrW(AddrW)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .nof_bits_i   (nof_bits_i),
      .op_i         (op_i),
      .base_i       (base_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o),
      .pair_valid_o (pair_valid_o),
      .pair_ready_i (pair_ready_i),
      .addr_a_o     (addr_a_o),
      .addr_b_o     (addr_b_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: bit-reverse by repeated division, qualify, then scale.
   function automatic void push_expected(input int n, input bitrev_pq_op_e op,
                                         input logic [31:0] base);
      pair_t p;
      bit    q;
      int    mult;
      mult = (op == BitrevOpPqShift) ? 4 : 1;
      for (int i = 0; i < (1 << n); i++) begin
         int j = 0;
         int t = i;
         for (int b = 0; b < n; b++) begin
            j = j * 2 + t % 2;
            t = t / 2;
         end
`ifdef OTBN_PQ_BITREV_SKIP_EN
         q = (i < j);
`else
         q = 1'b1;
`endif
         if (q) begin
            p.a = base + 32'(i * mult);
            p.b = base + 32'(j * mult);
            exp_q.push_back(p);
         end
      end
   endfunction

   always @(posedge clk_i) begin
      #1;
      case (rdy_mode)
         0: pair_ready_i = 1'b1;
         1: pair_ready_i = !pair_ready_i;
         2: pair_ready_i = 1'($urandom_range(0, 1));
         default: pair_ready_i = 1'b0;
      endcase
   end

   logic        prev_stall = 1'b0;
   logic [31:0] prev_a, prev_b;
   pair_t       mp;

   always @(negedge clk_i) begin
      if (rst_i) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", 64'(pair_valid_o), 64'd1);
            check("hold_addr_a", 64'(addr_a_o), 64'(prev_a));
            check("hold_addr_b", 64'(addr_b_o), 64'(prev_b));
         end
         if (pair_valid_o && pair_ready_i) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pair actual=(%0h,%0h) required=none", addr_a_o, addr_b_o);
            end else begin
               mp = exp_q.pop_front();
               check("pair_addr_a", 64'(addr_a_o), 64'(mp.a));
               check("pair_addr_b", 64'(addr_b_o), 64'(mp.b));
            end
         end
         if (pair_valid_o && !pair_ready_i) stalls++;
         prev_stall = pair_valid_o && !pair_ready_i;
         prev_a     = addr_a_o;
         prev_b     = addr_b_o;
      end
   end

   task automatic run(input int n, input bitrev_pq_op_e op, input logic [31:0] base,
                      input int mode, input bit poke);
      int lat;
      rdy_mode = mode;
      @(posedge clk_i); #1;
      push_expected(n, op, base);
      stalls     = 0;
      start_i    = 1'b1;
      nof_bits_i = n[NbW-1:0];
      op_i       = op;
      base_i     = base;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      check("busy_after_start", 64'(busy_o), 64'd1);
      lat = -1;
      for (int k = 1; k < 20000 && lat < 0; k++) begin
         @(posedge clk_i); #1;
         if (poke && k == 3) begin
            start_i    = 1'b1;
            nof_bits_i = NbW'(5);
            base_i     = 32'h5555_0000;
         end
         if (poke && k == 4) begin
            check("start_in_run_no_err", 64'(err_o), 64'd0);
            start_i = 1'b0;
         end
         if (done_o) lat = k;
      end
      if (lat < 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=none required=done_o");
         exp_q.delete();
      end else begin
         check("done_latency", 64'(lat), 64'((1 << n) + 2 + stalls));
      end
      check("busy_at_done", 64'(busy_o), 64'd0);
      @(posedge clk_i); #1;
      check("done_single_pulse", 64'(done_o), 64'd0);
      check("all_pairs_seen", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   task automatic bad_start(input int n);
      @(posedge clk_i); #1;
      start_i    = 1'b1;
      nof_bits_i = n[NbW-1:0];
      op_i       = BitrevOpPq;
      base_i     = 32'h0;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      check("err_pulse", 64'(err_o), 64'd1);
      check("err_busy", 64'(busy_o), 64'd0);
      check("err_valid", 64'(pair_valid_o), 64'd0);
      @(posedge clk_i); #1;
      check("err_pulse_end", 64'(err_o), 64'd0);
      check("err_busy_after", 64'(busy_o), 64'd0);
      check("err_valid_after", 64'(pair_valid_o), 64'd0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_busy"}, 64'(busy_o), 64'd0);
      check({tag, "_done"}, 64'(done_o), 64'd0);
      check({tag, "_err"}, 64'(err_o), 64'd0);
      check({tag, "_valid"}, 64'(pair_valid_o), 64'd0);
      check({tag, "_addr_a"}, 64'(addr_a_o), 64'd0);
      check({tag, "_addr_b"}, 64'(addr_b_o), 64'd0);
   endtask

   initial begin
      bit seen;
      rst_i        = 1'b1;
      start_i      = 1'b0;
      nof_bits_i   = '0;
      op_i         = BitrevOpPq;
      base_i       = '0;
      pair_ready_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      check_zero_outputs("reset");
      rst_i = 1'b0;

      run(3, BitrevOpPq, 32'h100, 0, 1'b0);
      run(4, BitrevOpPqShift, 32'h0, 0, 1'b0);
      run(2, BitrevOpPq, 32'h0, 0, 1'b0);
      run(3, BitrevOpPq, 32'h100, 1, 1'b0);
      run(1, BitrevOpPq, 32'h40, 0, 1'b0);
      run(3, BitrevOpPqShift, 32'hFFFF_FFF8, 2, 1'b0);
      run(4, BitrevOpPq, 32'h2000, 0, 1'b1);
      run(12, BitrevOpPqShift, 32'h1000_0000, 0, 1'b0);

      bad_start(0);
      bad_start(13);
      bad_start(15);

      for (int r = 0; r < 12; r++) begin
         run(int'($urandom_range(1, 6)), bitrev_pq_op_e'($urandom_range(0, 1)),
             $urandom, r % 3, 1'b0);
      end

      // Abort a stalled long run with reset, then restart with a short one.
      rdy_mode = 3;
      @(posedge clk_i); #1;
      start_i    = 1'b1;
      nof_bits_i = NbW'(12);
      op_i       = BitrevOpPq;
      base_i     = 32'h300;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(posedge clk_i); #1;
         if (pair_valid_o) seen = 1'b1;
      end
      check("stall_pair_presented", 64'(seen), 64'd1);
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      check_zero_outputs("abort");
      rst_i = 1'b0;
      exp_q.delete();
      run(1, BitrevOpPq, 32'h0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
